hd44780_ctrl: RTL and testbench
===============================

// Module: hd44780_ctrl
// PURPOSE
//  Write-only HD44780 LCD controller, 8-bit bus mode. After power-up it runs the
//  controller init sequence, then reads 32 characters from the character ROM
//  (rom_addr -> rom_data, combinational, DDRAM-style addresses) and writes them
//  to LCD line 1 (0x00-0x0F) and line 2 (0x40-0x4F). Sits between the ROM and
//  the LCD pins. A refresh request re-writes both lines without re-running init.
// PARAMETERS
//  POWERON_CYCLES  180000  wait after reset before the first write (15 ms @ 12 MHz)
//  CMD_CYCLES      600     execute wait after a normal command/data write (50 us)
//  LONG_CYCLES     60000   execute wait after the first function set and clear (5 ms)
//  SETUP_CYCLES    2       RS/DB valid before E rises
//  E_CYCLES        6       E high width
//  HOLD_CYCLES     2       RS/DB held after E falls
//  All values 1..2^20-1; one shared 20-bit down-counter.
// PORTS
//  clk       in   1  system clock
//  rst       in   1  asynchronous, active-high reset
//  refresh   in   1  one-cycle request to rewrite both lines; honoured only in DONE
//  rom_addr  out  7  character ROM address
//  rom_data  in   8  character ROM data, valid same cycle as rom_addr
//  lcd_rs    out  1  0 = command, 1 = character data
//  lcd_rw    out  1  constant 0 (write only)
//  lcd_e     out  1  LCD enable strobe
//  lcd_db    out  8  LCD data bus
//  busy      out  1  1 in every state except DONE
// BEHAVIOUR
//  Reset: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db=8'h00, rom_addr=7'h00, busy=1,
//   step=0, state=POWERON, counter=POWERON_CYCLES. Reset mid-transfer drops lcd_e
//   immediately and restarts from POWERON, including the full init.
//  States: POWERON -> LOAD -> SETUP -> EHIGH -> EHOLD -> WAIT -> (LOAD | DONE).
//  POWERON: count down, then go to LOAD.
//  Step table, 41 steps (0..40):
//   0-3 cmd 0x38 (function set, 8-bit, 2 lines); 4 cmd 0x0C (display on);
//   5 cmd 0x01 (clear); 6 cmd 0x06 (entry mode, increment);
//   7 cmd 0x80; 8-23 data from rom_addr = step-8;
//   24 cmd 0xC0; 25-40 data from rom_addr = 0x40+(step-25).
//  LOAD (1 cycle): drive rom_addr for data steps; register lcd_db (table value,
//   or rom_data for data steps) and lcd_rs; counter=SETUP_CYCLES.
//   Changing rom_addr on command steps is not required.
//  SETUP: lcd_e=0 for SETUP_CYCLES, then EHIGH.
//  EHIGH: lcd_e=1 for exactly E_CYCLES clocks, then EHOLD.
//  EHOLD: lcd_e=0; hold lcd_db/lcd_rs for HOLD_CYCLES, then WAIT.
//  WAIT: wait LONG_CYCLES after steps 0 and 5 and CMD_CYCLES after all others.
//   Then step+1 -> LOAD, or DONE after step 40.
//  lcd_db and lcd_rs change only in LOAD. lcd_e is glitch-free, registered.
//  DONE: busy=0, bus idle (lcd_e=0, lcd_db and lcd_rs unchanged).
//   refresh=1 -> step=7, LOAD (busy=1 next cycle).
//   refresh while busy is ignored, not queued.
//  Counter reaching 0 advances the state. Each wait lasts exactly its parameter in
//   cycles, with no extra idle cycle.
// TESTING  (sim params: POWERON=20, CMD=5, LONG=10, SETUP=2, E=3, HOLD=2)
//  Hold rst high, release -> all outputs at reset values; first lcd_e rise at
//   cycle 20+1+2 after release, with lcd_db=0x38 and lcd_rs=0.
//  Full run with ROM model (addr -> 8'h41+addr[3:0]) -> 41 E pulses logged in
//   order: 0x38 x4, 0x0C, 0x01, 0x06, 0x80, 'A'..'P', 0xC0, 'A'..'P'. rs=1 only
//   on data steps. Then busy=0.
//  Timing check on every pulse: E high exactly 3 cycles. DB stable 2 cycles
//   before the rise and 2 after the fall. Gap after steps 0 and 5 is 10 wait cycles.
//  In DONE, pulse refresh -> next write is 0x80, then 33 more writes. No 0x38 or
//   0x01 appears.
//  refresh pulsed during init at step 3 -> no effect. Sequence completes
//   unchanged and busy falls once.
//  Assert rst while lcd_e=1 at step 12 -> lcd_e=0 in the same cycle. After
//   release, full POWERON and init repeat.

Source files
------------

// File: rtl/hd44780_ctrl.sv
// Write-only HD44780 controller (8-bit bus). It runs the power-up init sequence, then copies 32 ROM
// characters to display lines 1 and 2. A refresh in DONE rewrites both lines without running init again.
module hd44780_ctrl #(
    parameter int unsigned POWERON_CYCLES = 180000,
    parameter int unsigned CMD_CYCLES     = 600,
    parameter int unsigned LONG_CYCLES    = 60000,
    parameter int unsigned SETUP_CYCLES   = 2,
    parameter int unsigned E_CYCLES       = 6,
    parameter int unsigned HOLD_CYCLES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refresh,
    output logic [6:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db,
    output logic       busy
);
    typedef enum logic [2:0] {
        POWERON = 3'd0,
        LOAD    = 3'd1,
        SETUP   = 3'd2,
        EHIGH   = 3'd3,
        EHOLD   = 3'd4,
        WAIT    = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [19:0] POWERON_C  = 20'(POWERON_CYCLES);
    localparam logic [19:0] CMD_C      = 20'(CMD_CYCLES);
    localparam logic [19:0] LONG_C     = 20'(LONG_CYCLES);
    localparam logic [19:0] SETUP_C    = 20'(SETUP_CYCLES);
    localparam logic [19:0] E_C        = 20'(E_CYCLES);
    localparam logic [19:0] HOLD_C     = 20'(HOLD_CYCLES);
    localparam logic [5:0]  STEP_LAST  = 6'd40;
    localparam logic [5:0]  STEP_LINE1 = 6'd7;

    state_t      state_r, state_s;
    logic [5:0]  step_r, step_s;
    logic [19:0] cnt_r, cnt_s;
    logic [6:0]  rom_addr_r, rom_addr_s;
    logic [7:0]  lcd_db_r, lcd_db_s;
    logic        lcd_rs_r, lcd_rs_s;
    logic        lcd_e_r;
    logic        busy_r;
    logic        cnt_last_s;

    function automatic logic is_data(input logic [5:0] s);
        is_data = ((s >= 6'd8) && (s <= 6'd23)) || ((s >= 6'd25) && (s <= 6'd40));
    endfunction

    function automatic logic [7:0] cmd_byte(input logic [5:0] s);
        case (s)
            6'd0, 6'd1, 6'd2, 6'd3: cmd_byte = 8'h38;
            6'd4:                   cmd_byte = 8'h0C;
            6'd5:                   cmd_byte = 8'h01;
            6'd6:                   cmd_byte = 8'h06;
            6'd7:                   cmd_byte = 8'h80;
            6'd24:                  cmd_byte = 8'hC0;
            default:                cmd_byte = 8'h00;
        endcase
    endfunction

    // Line 1 data steps map to DDRAM 0x00.., line 2 data steps map to 0x40..
    function automatic logic [6:0] next_addr(input logic [5:0] s, input logic [6:0] cur);
        if (!is_data(s)) begin
            next_addr = cur;
        end else if (s <= 6'd23) begin
            next_addr = 7'(s - 6'd8);
        end else begin
            next_addr = 7'h40 + 7'(s - 6'd25);
        end
    endfunction

    // Next-state, counter and bus-value logic
    always_comb begin
        state_s    = state_r;
        step_s     = step_r;
        cnt_s      = cnt_r;
        rom_addr_s = rom_addr_r;
        lcd_db_s   = lcd_db_r;
        lcd_rs_s   = lcd_rs_r;
        cnt_last_s = (cnt_r <= 20'd1);
        case (state_r)
            POWERON: begin
                if (cnt_last_s) begin
                    state_s = LOAD;
                end else begin
                    cnt_s = cnt_r - 20'd1;
                end
            end
            LOAD: begin
                state_s  = SETUP;
                cnt_s    = SETUP_C;
                lcd_rs_s = is_data(step_r);
                if (is_data(step_r)) begin
                    lcd_db_s = rom_data;
                end else begin
                    lcd_db_s = cmd_byte(step_r);
                end
            end
            SETUP: begin
                if (cnt_last_s) begin
                    state_s = EHIGH;
                    cnt_s   = E_C;
                end else begin
                    cnt_s = cnt_r - 20'd1;
                end
            end
            EHIGH: begin
                if (cnt_last_s) begin
                    state_s = EHOLD;
                    cnt_s   = HOLD_C;
                end else begin
                    cnt_s = cnt_r - 20'd1;
                end
            end
            EHOLD: begin
                if (cnt_last_s) begin
                    state_s = WAIT;
                    cnt_s   = ((step_r == 6'd0) || (step_r == 6'd5)) ? LONG_C : CMD_C;
                end else begin
                    cnt_s = cnt_r - 20'd1;
                end
            end
            WAIT: begin
                if (cnt_last_s) begin
                    if (step_r == STEP_LAST) begin
                        state_s = DONE;
                    end else begin
                        state_s    = LOAD;
                        step_s     = step_r + 6'd1;
                        rom_addr_s = next_addr(step_r + 6'd1, rom_addr_r);
                    end
                end else begin
                    cnt_s = cnt_r - 20'd1;
                end
            end
            DONE: begin
                if (refresh) begin
                    state_s = LOAD;
                    step_s  = STEP_LINE1;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = POWERON;
                step_s  = 6'd0;
                cnt_s   = POWERON_C;
            end
        endcase
    end

    // State, counter and registered LCD/ROM outputs; reset drops E at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= POWERON;
            step_r     <= 6'd0;
            cnt_r      <= POWERON_C;
            rom_addr_r <= 7'h00;
            lcd_db_r   <= 8'h00;
            lcd_rs_r   <= 1'b0;
            lcd_e_r    <= 1'b0;
            busy_r     <= 1'b1;
        end else begin
            state_r    <= state_s;
            step_r     <= step_s;
            cnt_r      <= cnt_s;
            rom_addr_r <= rom_addr_s;
            lcd_db_r   <= lcd_db_s;
            lcd_rs_r   <= lcd_rs_s;
            lcd_e_r    <= (state_s == EHIGH);
            busy_r     <= (state_s != DONE);
        end
    end

    assign rom_addr = rom_addr_r;
    assign lcd_db   = lcd_db_r;
    assign lcd_rs   = lcd_rs_r;
    assign lcd_e    = lcd_e_r;
    assign lcd_rw   = 1'b0;
    assign busy     = busy_r;
endmodule

// File: tb/tb_hd44780_ctrl.sv
// Bench for hd44780_ctrl: a timeline model derived from write order and per-write timing,
// a per-cycle compare, and a pulse log checked against the expected character sequence.
module tb_hd44780_ctrl;
    localparam int P_POWERON = 20;
    localparam int P_CMD     = 5;
    localparam int P_LONG    = 10;
    localparam int P_SETUP   = 2;
    localparam int P_E       = 3;
    localparam int P_HOLD    = 2;
    // Edges from one DB latch to the next, not counting the execute wait
    localparam int P_WRITE   = P_SETUP + P_E + P_HOLD + 1;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       refresh = 1'b0;
    logic [6:0] rom_addr;
    logic [7:0] rom_data;
    logic       lcd_rs, lcd_rw, lcd_e, busy;
    logic [7:0] lcd_db;

    int passed = 0;
    int total  = 0;

    int         n          = 0;
    int         base_d     = P_POWERON + 1;
    int         first_step = 0;
    logic [7:0] prev_db    = 8'h00;
    logic       prev_rs    = 1'b0;
    logic [10:0] m_now;

    logic [7:0] log_db[$];
    logic       log_rs[$];
    int         log_rise[$];
    int         log_width[$];
    logic [7:0] log_pre[$];
    logic [7:0] log_post[$];
    logic       prev_e    = 1'b0;
    logic       prev_busy = 1'b1;
    int         post_cnt  = 0;
    int         falls     = 0;
    logic [7:0] db_h1     = 8'h00;
    logic [7:0] db_h2     = 8'h00;

    always #5 clk = ~clk;

    assign rom_data = 8'h41 + {4'h0, rom_addr[3:0]};

    hd44780_ctrl #(
        .POWERON_CYCLES(P_POWERON), .CMD_CYCLES(P_CMD), .LONG_CYCLES(P_LONG),
        .SETUP_CYCLES(P_SETUP), .E_CYCLES(P_E), .HOLD_CYCLES(P_HOLD)
    ) dut (
        .clk(clk), .rst(rst), .refresh(refresh), .rom_addr(rom_addr), .rom_data(rom_data),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db), .busy(busy)
    );

    function automatic logic [7:0] exp_byte(input int k);
        if (k <= 3)       return 8'h38;
        else if (k == 4)  return 8'h0C;
        else if (k == 5)  return 8'h01;
        else if (k == 6)  return 8'h06;
        else if (k == 7)  return 8'h80;
        else if (k <= 23) return 8'h41 + 8'(k - 8);
        else if (k == 24) return 8'hC0;
        else              return 8'h41 + 8'(k - 25);
    endfunction

    function automatic bit is_data(input int k);
        return (k >= 8) && (k != 24);
    endfunction

    function automatic int wait_of(input int k);
        return ((k == 0) || (k == 5)) ? P_LONG : P_CMD;
    endfunction

    // Expected {e, rs, busy, db} m edges into a run whose first write latches DB at edge base
    function automatic logic [10:0] model_out(input int m, input int base, input int fstep,
                                              input logic [7:0] pdb, input logic prs);
        int d;
        d = base;
        if (m < d) return {1'b0, prs, 1'b1, pdb};
        for (int k = fstep; k <= 40; k++) begin
            int w;
            w = wait_of(k);
            if ((k == 40) || (m < d + P_WRITE + w))
                return {((m - d) >= P_SETUP) && ((m - d) < P_SETUP + P_E), is_data(k),
                        !((k == 40) && (m >= d + P_WRITE - 1 + w)), exp_byte(k)};
            d = d + P_WRITE + w;
        end
        return 11'h000;
    endfunction

    assign m_now = model_out(n, base_d, first_step, prev_db, prev_rs);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    endtask

    // Model timeline: edge count since release, restarted by a refresh honoured in DONE
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n          <= 0;
            base_d     <= P_POWERON + 1;
            first_step <= 0;
            prev_db    <= 8'h00;
            prev_rs    <= 1'b0;
        end else begin
            n <= n + 1;
            if (refresh && !m_now[8]) begin
                base_d     <= n + 2;
                first_step <= 7;
                prev_db    <= m_now[7:0];
                prev_rs    <= m_now[9];
            end
        end
    end

    // Per-cycle compare of all LCD outputs against the model
    always @(negedge clk) begin
        check($sformatf("cycle%0d", n), {lcd_e, lcd_rs, busy, lcd_db, lcd_rw}, {m_now, 1'b0});
    end

    // Pulse logger: DB at rise, DB two cycles before rise and after fall, E width, busy falls
    always @(negedge clk) begin
        if (rst) begin
            prev_e   <= 1'b0;
            post_cnt <= 0;
        end else begin
            prev_e <= lcd_e;
            if (lcd_e && !prev_e) begin
                log_db.push_back(lcd_db);
                log_rs.push_back(lcd_rs);
                log_rise.push_back(n);
                log_pre.push_back(db_h2);
            end
            if (!lcd_e && prev_e && (log_rise.size() > 0)) begin
                log_width.push_back(n - log_rise[log_rise.size() - 1]);
                post_cnt <= 2;
            end else if (post_cnt == 1) begin
                log_post.push_back(lcd_db);
                post_cnt <= 0;
            end else if (post_cnt > 0) begin
                post_cnt <= post_cnt - 1;
            end
        end
        db_h1     <= lcd_db;
        db_h2     <= db_h1;
        prev_busy <= busy;
        if (prev_busy && !busy) falls <= falls + 1;
    end

    task automatic clear_log();
        log_db.delete(); log_rs.delete(); log_rise.delete();
        log_width.delete(); log_pre.delete(); log_post.delete();
    endtask

    task automatic wait_log(input int cnt, input int max_cyc);
        int i;
        i = 0;
        while ((log_db.size() < cnt) && (i < max_cyc)) begin
            @(negedge clk);
            i++;
        end
        check("log_wait_timeout", 32'(log_db.size() >= cnt), 32'd1);
    endtask

    task automatic wait_busy_low(input int max_cyc);
        int i;
        i = 0;
        while ((busy !== 1'b0) && (i < max_cyc)) begin
            @(negedge clk);
            i++;
        end
        check("busy_low_timeout", {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
    endtask

    task automatic check_run(input int fstep, input int nexp);
        check("pulse_count", log_db.size(), nexp);
        for (int k = 0; (k < nexp) && (k < log_db.size()); k++) begin
            check($sformatf("db_w%0d", k), log_db[k], exp_byte(fstep + k));
            check($sformatf("rs_w%0d", k), {31'd0, log_rs[k]}, {31'd0, is_data(fstep + k)});
            check($sformatf("ewidth_w%0d", k), log_width[k], P_E);
            check($sformatf("db_pre_w%0d", k), log_pre[k], log_db[k]);
            check($sformatf("db_post_w%0d", k), log_post[k], log_db[k]);
        end
    endtask

    initial begin
        int f0;
        int bad;
        repeat (3) @(negedge clk);
        check("reset_outputs", {lcd_e, lcd_rs, lcd_rw, busy, lcd_db}, {4'b0001, 8'h00});
        check("reset_rom_addr", rom_addr, 7'h00);

        // Full init and both lines; a refresh at step 3 must be ignored
        rst = 1'b0;
        clear_log();
        f0 = falls;
        wait_log(4, 400);
        pulse_refresh();
        wait_busy_low(2000);
        check_run(0, 41);
        if (log_db.size() == 41) begin
            check("first_rise_cycle", log_rise[0], 23);
            check("first_db", log_db[0], 8'h38);
            check("first_rs", {31'd0, log_rs[0]}, 32'd0);
            check("gap_after_step0", log_rise[1] - log_rise[0], 18);
            check("gap_after_step1", log_rise[2] - log_rise[1], 13);
            check("gap_after_step5", log_rise[6] - log_rise[5], 18);
            check("line1_first_char", log_db[8], 8'h41);
            check("line2_cmd", log_db[24], 8'hC0);
            check("line2_last_char", log_db[40], 8'h50);
        end
        check("busy_falls_once", falls - f0, 1);

        // Refresh from DONE: line writes only
        repeat (4) @(negedge clk);
        check("done_busy", {31'd0, busy}, 32'd0);
        clear_log();
        pulse_refresh();
        check("refresh_busy", {31'd0, busy}, 32'd1);
        wait_busy_low(2000);
        check_run(7, 34);
        bad = 0;
        foreach (log_db[k]) if ((log_db[k] == 8'h38) || (log_db[k] == 8'h01)) bad++;
        check("no_init_cmds", bad, 0);
        if (log_db.size() > 0) check("refresh_first_db", log_db[0], 8'h80);

        // Reset while E is high at step 12, then full restart
        repeat (3) @(negedge clk);
        clear_log();
        pulse_refresh();
        wait_log(6, 400);
        check("e_high_before_reset", {31'd0, lcd_e}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("reset_mid_e", {31'd0, lcd_e}, 32'd0);
        check("reset_mid_bus", {busy, lcd_rs, lcd_db}, {2'b10, 8'h00});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        wait_busy_low(2000);
        check_run(0, 41);
        if (log_db.size() == 41) begin
            check("restart_first_rise", log_rise[0], 23);
            check("restart_clear", log_db[5], 8'h01);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
